// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters, with a no-ack watchdog.
// Arbitration latency: 1 cycle. No backpressure: a frame ends only when its owner drops cyc.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              iClk,
  input  logic                              nRst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_write,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [2*NUM_MASTERS-1:0]          m_width,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_data_read,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_data_write,
  output logic                              s_we,
  output logic                              s_stb,
  output logic                              s_cyc,
  output logic [1:0]                        s_width,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_data_read,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] last;
  logic [WD_W-1:0]  wdog;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_cyc;
  int               cand;

  // Scan last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = int'(last) + off;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!pick_vld && m_cyc[IDX_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Owner's request is forwarded only in OWN; ABORT and IDLE present a quiet bus.
  always_comb begin
    s_addr       = '0;
    s_data_write = '0;
    s_we         = 1'b0;
    s_stb        = 1'b0;
    s_cyc        = 1'b0;
    s_width      = 2'b00;
    m_ack        = '0;
    owner_cyc    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        owner_cyc = m_cyc[i];
        if (state == OWN) begin
          s_addr       = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_data_write = m_data_write[i*DATA_WIDTH +: DATA_WIDTH];
          s_we         = m_we[i];
          s_stb        = m_stb[i];
          s_cyc        = m_cyc[i];
          s_width      = m_width[i*2 +: 2];
          m_ack[i]     = s_ack;
        end
      end
    end
  end

  assign m_data_read = s_data_read;
  assign busy        = (state != IDLE);

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
      wdog  <= '0;
      m_err <= '0;
    end else begin
      m_err <= '0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_vld) begin
            grant <= NUM_MASTERS'(1) << pick_idx;
            gidx  <= pick_idx;
            state <= OWN;
          end
        end
        OWN: begin
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= '0;
            last  <= gidx;
            wdog  <= '0;
          end else if (s_stb && !s_ack && WD_EN) begin
            if (wdog == WD_MAX) begin
              state <= ABORT;
              m_err <= grant;
              wdog  <= '0;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= '0;
            last  <= gidx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: 3 masters, 8-cycle watchdog.
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            iClk = 1'b0;
  logic            nRst;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data_write;
  logic [N-1:0]    m_we, m_stb, m_cyc;
  logic [2*N-1:0]  m_width;
  logic [N-1:0]    m_ack, m_err;
  logic [DW-1:0]   m_data_read;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_data_write;
  logic            s_we, s_stb, s_cyc;
  logic [1:0]      s_width;
  logic            s_ack;
  logic [DW-1:0]   s_data_read;
  logic [N-1:0]    grant;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 iClk = ~iClk;

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
    .iClk(iClk), .nRst(nRst),
    .m_addr(m_addr), .m_data_write(m_data_write), .m_we(m_we), .m_stb(m_stb),
    .m_cyc(m_cyc), .m_width(m_width), .m_ack(m_ack), .m_err(m_err),
    .m_data_read(m_data_read),
    .s_addr(s_addr), .s_data_write(s_data_write), .s_we(s_we), .s_stb(s_stb),
    .s_cyc(s_cyc), .s_width(s_width), .s_ack(s_ack), .s_data_read(s_data_read),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [31:0] addr, input logic [31:0] data);
    m_addr[i*AW +: AW]       = addr;
    m_data_write[i*DW +: DW] = data;
    m_width[i*2 +: 2]        = 2'b10;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    #2;
    nRst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    nRst = 1'b0;
    m_addr = '0; m_data_write = '0; m_we = '0; m_stb = '0; m_cyc = '0; m_width = '0;
    s_ack = 1'b0; s_data_read = '0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_m_err", 32'(m_err), 32'h0);
    nRst = 1'b1;

    // Single write by master0; slave acks two cycles after stb.
    set_master(0, 32'h100, 32'hDEADBEEF);
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001;
    #1;
    chk("t1_c0_s_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("t1_c1_s_cyc",  32'(s_cyc),  32'h1);
    chk("t1_c1_addr",   s_addr,      32'h100);
    chk("t1_c1_wdata",  s_data_write, 32'hDEADBEEF);
    chk("t1_c1_we",     32'(s_we),   32'h1);
    chk("t1_c1_width",  32'(s_width), 32'h2);
    chk("t1_c1_grant",  32'(grant),  32'h1);
    chk("t1_c1_busy",   32'(busy),   32'h1);
    chk("t1_c1_ack",    32'(m_ack),  32'h0);
    step();
    step();
    s_ack = 1'b1; s_data_read = 32'h12345678;
    #1;
    chk("t1_c3_ack",   32'(m_ack),  32'h1);
    chk("t1_c3_rdata", m_data_read, 32'h12345678);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    #1;
    chk("t1_drop_s_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_busy",  32'(busy),  32'h0);

    // Two simultaneous requests after reset; master0 first, master1 after one idle cycle.
    do_reset();
    set_master(0, 32'h200, 32'h0);
    set_master(1, 32'h300, 32'h0);
    m_cyc = 3'b011; m_stb = 3'b011;
    step();
    chk("t2_grant0", 32'(grant),  32'h1);
    chk("t2_addr0",  s_addr,      32'h200);
    s_ack = 1'b1;
    #1;
    chk("t2_ack0",   32'(m_ack),  32'h1);
    step();
    s_ack = 1'b0; m_cyc = 3'b010; m_stb = 3'b010;
    #1;
    chk("t2_drop_s_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("t2_idle_grant", 32'(grant), 32'h0);
    chk("t2_idle_s_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("t2_grant1", 32'(grant), 32'h2);
    chk("t2_addr1",  s_addr,     32'h300);
    m_cyc = '0; m_stb = '0;
    step();

    // All three requesting; one transfer per frame -> 0,1,2,0,1.
    do_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_grant_f%0d", k), 32'(grant), 32'(1 << (k % 3)));
      s_ack = 1'b1;
      #1;
      chk($sformatf("t3_ack_f%0d", k), 32'(m_ack), 32'(1 << (k % 3)));
      step();
      s_ack = 1'b0;
      m_cyc = 3'b111 & ~3'(1 << (k % 3));
      step();
      m_cyc = 3'b111;
      #1;
      chk($sformatf("t3_idle_f%0d", k), 32'(grant), 32'h0);
      step();
    end
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Watchdog: master2 alone, slave never acks (last owner was master1).
    set_master(2, 32'h400, 32'h0);
    m_cyc = 3'b100; m_stb = 3'b100;
    #1;
    chk("t4_c0_grant", 32'(grant), 32'h0);
    step();
    chk("t4_c1_grant", 32'(grant), 32'h4);
    chk("t4_c1_stb",   32'(s_stb), 32'h1);
    repeat (7) step();
    chk("t4_c8_err",   32'(m_err), 32'h0);
    chk("t4_c8_stb",   32'(s_stb), 32'h1);
    step();
    chk("t4_c9_err",   32'(m_err), 32'h4);
    chk("t4_c9_s_cyc", 32'(s_cyc), 32'h0);
    chk("t4_c9_s_stb", 32'(s_stb), 32'h0);
    chk("t4_c9_grant", 32'(grant), 32'h4);
    chk("t4_c9_busy",  32'(busy),  32'h1);
    step();
    chk("t4_c10_err",  32'(m_err), 32'h0);
    chk("t4_c10_grant", 32'(grant), 32'h4);
    s_ack = 1'b1;
    set_master(0, 32'h500, 32'h0);
    m_cyc = 3'b001; m_stb = 3'b001;
    #1;
    chk("t4_abort_stray_ack", 32'(m_ack), 32'h0);
    chk("t4_abort_s_cyc",     32'(s_cyc), 32'h0);
    step();
    chk("t4_idle_stray_ack", 32'(m_ack), 32'h0);
    chk("t4_idle_grant",     32'(grant), 32'h0);
    s_ack = 1'b0;
    step();
    chk("t4_rearb_grant", 32'(grant), 32'h1);
    chk("t4_rearb_addr",  s_addr,     32'h500);

    // Ack coincident with the watchdog limit: ack wins, counter restarts.
    repeat (7) step();
    s_ack = 1'b1;
    #1;
    chk("t6_limit_ack", 32'(m_ack), 32'h1);
    step();
    s_ack = 1'b0;
    #1;
    chk("t6_no_err",  32'(m_err), 32'h0);
    chk("t6_own",     32'(s_cyc), 32'h1);
    chk("t6_grant",   32'(grant), 32'h1);
    repeat (7) step();
    chk("t6_wdog_restart_err", 32'(m_err), 32'h0);
    chk("t6_wdog_restart_cyc", 32'(s_cyc), 32'h1);

    // Asynchronous reset mid-frame, then master0 regains priority over master1.
    s_ack = 1'b1;
    #1;
    chk("t5_pre_ack", 32'(m_ack), 32'h1);
    nRst = 1'b0;
    #1;
    chk("t5_s_cyc", 32'(s_cyc), 32'h0);
    chk("t5_s_stb", 32'(s_stb), 32'h0);
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_m_ack", 32'(m_ack), 32'h0);
    chk("t5_busy",  32'(busy),  32'h0);
    s_ack = 1'b0;
    m_cyc = 3'b011; m_stb = 3'b011;
    nRst = 1'b1;
    step();
    chk("t5_prio_grant", 32'(grant), 32'h1);
    m_cyc = '0; m_stb = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
